// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Hack CPU instruction fetch stage. Holds the program counter,
//            issues one request at a time to a variable-latency instruction
//            ROM (req/ack) and hands each fetched word plus its address to
//            decode/execute (valid/ready). Taken jumps redirect the fetch.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    output logic              rom_req,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic              rom_ack,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_addr
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    logic [1:0]        state;
    logic [1:0]        state_next;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_next;
    logic [ADDR_W-1:0] fetch_addr;
    logic [ADDR_W-1:0] rom_addr_next;
    logic              rom_req_next;
    logic [DATA_W-1:0] instr_next;
    logic [ADDR_W-1:0] instr_pc_next;
    logic              instr_valid_next;
    logic              kill;
    logic              kill_next;

    // A jump seen while idle is folded straight into the request being issued.
    assign fetch_addr = jump ? jump_addr : pc;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: a fetch completes into HOLD only if no redirect hit it.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: state_next = REQ;
            REQ: begin
                if (rom_ack) begin
                    state_next = (kill || jump) ? IDLE : HOLD;
                end
            end
            HOLD: begin
                if (instr_ready || jump) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output/datapath next values. A jump during an outstanding request cannot
    // cancel it on the bus, so it is remembered in kill and the data dropped.
    always_comb begin
        pc_next          = pc;
        rom_addr_next    = rom_addr;
        rom_req_next     = rom_req;
        instr_next       = instr;
        instr_pc_next    = instr_pc;
        instr_valid_next = instr_valid;
        kill_next        = kill;
        case (state)
            IDLE: begin
                pc_next       = fetch_addr;
                rom_addr_next = fetch_addr;
                rom_req_next  = 1'b1;
            end
            REQ: begin
                if (rom_ack) begin
                    rom_req_next = 1'b0;
                    kill_next    = 1'b0;
                    if (jump) begin
                        pc_next = jump_addr;
                    end else if (!kill) begin
                        instr_next       = rom_data;
                        instr_pc_next    = rom_addr;
                        instr_valid_next = 1'b1;
                        pc_next          = rom_addr + ADDR_W'(1);
                    end
                end else if (jump) begin
                    pc_next   = jump_addr;
                    kill_next = 1'b1;
                end
            end
            HOLD: begin
                if (instr_ready || jump) begin
                    instr_valid_next = 1'b0;
                end
                if (jump) begin
                    pc_next = jump_addr;
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers; reset abandons any outstanding request.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= '0;
            rom_addr    <= '0;
            rom_req     <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            kill        <= 1'b0;
        end else begin
            pc          <= pc_next;
            rom_addr    <= rom_addr_next;
            rom_req     <= rom_req_next;
            instr       <= instr_next;
            instr_pc    <= instr_pc_next;
            instr_valid <= instr_valid_next;
            kill        <= kill_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Self-checking bench for fetch_unit with a latency-programmable
//            ROM responder, directed scenarios and a randomized run checked
//            against a transaction-level model of the fetch stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rom_req;
    logic [14:0] rom_addr;
    logic        rom_ack = 1'b0;
    logic [15:0] rom_data = '0;
    logic [15:0] instr;
    logic [14:0] instr_pc;
    logic        instr_valid;
    logic        ready = 1'b0;
    logic        jump = 1'b0;
    logic [14:0] jump_addr = '0;

    int n_checks = 0;
    int n_fail   = 0;

    int   rom_lat   = 0;
    int   wait_cnt  = 0;
    logic force_ack = 1'b0;
    logic acked     = 1'b0;

    fetch_unit #(.ADDR_W(15), .DATA_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .rom_req    (rom_req),
        .rom_addr   (rom_addr),
        .rom_ack    (rom_ack),
        .rom_data   (rom_data),
        .instr      (instr),
        .instr_pc   (instr_pc),
        .instr_valid(instr_valid),
        .instr_ready(ready),
        .jump       (jump),
        .jump_addr  (jump_addr)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] rom_fn(input logic [14:0] a);
        return {1'b0, a} ^ 16'h8000;
    endfunction

    // One clock: ROM answers after rom_lat wait cycles; returns at posedge+1.
    task automatic cycle();
        @(negedge clk);
        acked    = (rom_req === 1'b1) && (wait_cnt >= rom_lat);
        rom_ack  = acked | force_ack;
        rom_data = acked ? rom_fn(rom_addr) : 16'($urandom);
        if ((rom_req === 1'b1) && !acked) wait_cnt++;
        else wait_cnt = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        jump  = 1'b0;
        cycle();
        cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if ({rom_req, rom_addr, instr, instr_pc, instr_valid} !== 48'd0) begin
            n_fail++;
            $display("FAIL reset_values: got req=%b addr=%h instr=%h pc=%h valid=%b expected all zero",
                     rom_req, rom_addr, instr, instr_pc, instr_valid);
        end
    endtask

    task automatic test_zero_wait();
        rom_lat = 0; ready = 1'b1;
        apply_reset();
        for (int k = 0; k < 3; k++) begin
            cycle();
            n_checks++;
            if ({rom_req, rom_addr, instr_valid} !== {1'b1, 15'(k), 1'b0}) begin
                n_fail++;
                $display("FAIL zw_req%0d: got req=%b addr=%h valid=%b expected req=1 addr=%h valid=0",
                         k, rom_req, rom_addr, instr_valid, 15'(k));
            end
            cycle();
            n_checks++;
            if ({instr_valid, instr, instr_pc, rom_req} !== {1'b1, 16'h8000 | 16'(k), 15'(k), 1'b0}) begin
                n_fail++;
                $display("FAIL zw_deliver%0d: got valid=%b instr=%h pc=%h req=%b expected 1/%h/%h/0",
                         k, instr_valid, instr, instr_pc, rom_req, 16'h8000 | 16'(k), 15'(k));
            end
            cycle();
            n_checks++;
            if ({instr_valid, rom_req} !== 2'b00) begin
                n_fail++;
                $display("FAIL zw_idle%0d: got valid=%b req=%b expected 0/0", k, instr_valid, rom_req);
            end
        end
    endtask

    task automatic test_wait_backpressure();
        int handoffs = 0;
        rom_lat = 3; ready = 1'b0;
        apply_reset();
        cycle();
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if ({rom_req, rom_addr, instr_valid} !== {1'b1, 15'h0000, 1'b0}) begin
                n_fail++;
                $display("FAIL wait_stable%0d: got req=%b addr=%h valid=%b expected 1/0000/0",
                         i, rom_req, rom_addr, instr_valid);
            end
            cycle();
        end
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if ({instr_valid, instr, instr_pc, rom_req} !== {1'b1, 16'h8000, 15'h0000, 1'b0}) begin
                n_fail++;
                $display("FAIL hold%0d: got valid=%b instr=%h pc=%h req=%b expected 1/8000/0000/0",
                         i, instr_valid, instr, instr_pc, rom_req);
            end
            if (instr_valid && ready) handoffs++;
            cycle();
        end
        ready = 1'b1;
        if (instr_valid && ready) handoffs++;
        cycle();
        if (instr_valid && ready) handoffs++;
        n_checks++;
        if ({instr_valid, rom_req} !== 2'b00 || handoffs != 1) begin
            n_fail++;
            $display("FAIL handoff: got valid=%b req=%b handoffs=%0d expected 0/0/1", instr_valid, rom_req, handoffs);
        end
        cycle();
        n_checks++;
        if ({rom_req, rom_addr} !== {1'b1, 15'h0001}) begin
            n_fail++;
            $display("FAIL next_req: got req=%b addr=%h expected 1/0001", rom_req, rom_addr);
        end
    endtask

    task automatic test_jump_in_req();
        rom_lat = 0; ready = 1'b1;
        apply_reset();
        repeat (6) cycle();
        rom_lat = 3;
        cycle();
        n_checks++;
        if ({rom_req, rom_addr} !== {1'b1, 15'h0002}) begin
            n_fail++;
            $display("FAIL jreq_setup: got req=%b addr=%h expected 1/0002", rom_req, rom_addr);
        end
        jump = 1'b1; jump_addr = 15'h1234;
        cycle();
        jump = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if ({rom_req, rom_addr, instr_valid} !== {1'b1, 15'h0002, 1'b0}) begin
                n_fail++;
                $display("FAIL jreq_wait%0d: got req=%b addr=%h valid=%b expected 1/0002/0",
                         i, rom_req, rom_addr, instr_valid);
            end
            cycle();
        end
        n_checks++;
        if ({instr_valid, rom_req} !== 2'b00) begin
            n_fail++;
            $display("FAIL jreq_discard: got valid=%b req=%b expected 0/0", instr_valid, rom_req);
        end
        cycle();
        n_checks++;
        if ({rom_req, rom_addr} !== {1'b1, 15'h1234}) begin
            n_fail++;
            $display("FAIL jreq_target: got req=%b addr=%h expected 1/1234", rom_req, rom_addr);
        end
        repeat (4) cycle();
        n_checks++;
        if ({instr_valid, instr, instr_pc} !== {1'b1, 16'h9234, 15'h1234}) begin
            n_fail++;
            $display("FAIL jreq_deliver: got valid=%b instr=%h pc=%h expected 1/9234/1234", instr_valid, instr, instr_pc);
        end
    endtask

    task automatic test_jump_in_hold();
        int handoffs = 0;
        rom_lat = 0; ready = 1'b0;
        apply_reset();
        cycle();
        cycle();
        jump = 1'b1; jump_addr = 15'h0555;
        if (instr_valid && ready) handoffs++;
        cycle();
        jump = 1'b0;
        n_checks++;
        if ({instr_valid, rom_req} !== 2'b00 || handoffs != 0) begin
            n_fail++;
            $display("FAIL jhold_drop: got valid=%b req=%b handoffs=%0d expected 0/0/0", instr_valid, rom_req, handoffs);
        end
        cycle();
        n_checks++;
        if ({rom_req, rom_addr} !== {1'b1, 15'h0555}) begin
            n_fail++;
            $display("FAIL jhold_target: got req=%b addr=%h expected 1/0555", rom_req, rom_addr);
        end
        cycle();
        n_checks++;
        if ({instr_valid, instr, instr_pc} !== {1'b1, 16'h8555, 15'h0555}) begin
            n_fail++;
            $display("FAIL jhold_deliver: got valid=%b instr=%h pc=%h expected 1/8555/0555", instr_valid, instr, instr_pc);
        end
    endtask

    task automatic test_jump_with_ack();
        rom_lat = 1; ready = 1'b1;
        apply_reset();
        cycle();
        cycle();
        jump = 1'b1; jump_addr = 15'h0AAA;
        cycle();
        jump = 1'b0;
        n_checks++;
        if ({instr_valid, rom_req} !== 2'b00) begin
            n_fail++;
            $display("FAIL jack_discard: got valid=%b req=%b expected 0/0", instr_valid, rom_req);
        end
        cycle();
        n_checks++;
        if ({rom_req, rom_addr} !== {1'b1, 15'h0AAA}) begin
            n_fail++;
            $display("FAIL jack_target: got req=%b addr=%h expected 1/0aaa", rom_req, rom_addr);
        end
    endtask

    task automatic test_wrap();
        rom_lat = 0; ready = 1'b1;
        apply_reset();
        jump = 1'b1; jump_addr = 15'h7FFF;
        cycle();
        jump = 1'b0;
        cycle();
        n_checks++;
        if ({instr_valid, instr, instr_pc} !== {1'b1, 16'hFFFF, 15'h7FFF}) begin
            n_fail++;
            $display("FAIL wrap_top: got valid=%b instr=%h pc=%h expected 1/ffff/7fff", instr_valid, instr, instr_pc);
        end
        repeat (3) cycle();
        n_checks++;
        if ({instr_valid, instr, instr_pc} !== {1'b1, 16'h8000, 15'h0000}) begin
            n_fail++;
            $display("FAIL wrap_zero: got valid=%b instr=%h pc=%h expected 1/8000/0000", instr_valid, instr, instr_pc);
        end
    endtask

    task automatic test_reset_mid_req();
        rom_lat = 3; ready = 1'b1;
        apply_reset();
        cycle();
        cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        n_checks++;
        if ({rom_req, instr_valid} !== 2'b00) begin
            n_fail++;
            $display("FAIL rst_abandon: got req=%b valid=%b expected 0/0", rom_req, instr_valid);
        end
        force_ack = 1'b1;
        cycle();
        force_ack = 1'b0;
        n_checks++;
        if ({rom_req, rom_addr, instr_valid} !== {1'b1, 15'h0000, 1'b0}) begin
            n_fail++;
            $display("FAIL rst_late_ack: got req=%b addr=%h valid=%b expected 1/0000/0", rom_req, rom_addr, instr_valid);
        end
        repeat (4) cycle();
        n_checks++;
        if ({instr_valid, instr, instr_pc} !== {1'b1, 16'h8000, 15'h0000}) begin
            n_fail++;
            $display("FAIL rst_first: got valid=%b instr=%h pc=%h expected 1/8000/0000", instr_valid, instr, instr_pc);
        end
    endtask

    // Model tracks the address the fetch stream should ask for next and
    // whether the request in flight has been overtaken by a redirect.
    task automatic test_random();
        logic [14:0] exp_next;
        logic        poisoned;
        logic        pre_req, pre_valid;
        logic [14:0] pre_addr, pre_pc;
        logic [15:0] pre_instr;
        apply_reset();
        exp_next = '0;
        poisoned = 1'b0;
        for (int c = 0; c < 800; c++) begin
            pre_req = rom_req; pre_addr = rom_addr; pre_valid = instr_valid;
            pre_instr = instr; pre_pc = instr_pc;
            if (c % 40 == 0) rom_lat = $urandom_range(0, 3);
            ready = ($urandom_range(0, 1) == 1);
            jump  = ($urandom_range(0, 9) == 0);
            jump_addr = ($urandom_range(0, 3) == 0) ? 15'h7FFE + 15'($urandom_range(0, 1)) : 15'($urandom);
            cycle();
            n_checks++;
            if (pre_req && acked) begin
                if (poisoned || jump) begin
                    if ({instr_valid, rom_req} !== 2'b00) begin
                        n_fail++;
                        $display("FAIL rnd_discard c=%0d: got valid=%b req=%b expected 0/0", c, instr_valid, rom_req);
                    end
                end else begin
                    if ({instr_valid, instr, instr_pc, rom_req} !== {1'b1, rom_fn(pre_addr), pre_addr, 1'b0}) begin
                        n_fail++;
                        $display("FAIL rnd_deliver c=%0d: got valid=%b instr=%h pc=%h req=%b expected 1/%h/%h/0",
                                 c, instr_valid, instr, instr_pc, rom_req, rom_fn(pre_addr), pre_addr);
                    end
                    exp_next = pre_addr + 15'd1;
                end
                poisoned = 1'b0;
            end else if (pre_req) begin
                if ({rom_req, rom_addr, instr_valid} !== {1'b1, pre_addr, 1'b0}) begin
                    n_fail++;
                    $display("FAIL rnd_wait c=%0d: got req=%b addr=%h valid=%b expected 1/%h/0",
                             c, rom_req, rom_addr, instr_valid, pre_addr);
                end
                if (jump) poisoned = 1'b1;
            end else if (pre_valid) begin
                if (ready || jump) begin
                    if ({instr_valid, rom_req} !== 2'b00) begin
                        n_fail++;
                        $display("FAIL rnd_release c=%0d: got valid=%b req=%b expected 0/0", c, instr_valid, rom_req);
                    end
                end else if ({instr_valid, instr, instr_pc, rom_req} !== {1'b1, pre_instr, pre_pc, 1'b0}) begin
                    n_fail++;
                    $display("FAIL rnd_hold c=%0d: got valid=%b instr=%h pc=%h req=%b expected 1/%h/%h/0",
                             c, instr_valid, instr, instr_pc, rom_req, pre_instr, pre_pc);
                end
            end else begin
                if ({rom_req, rom_addr, instr_valid} !== {1'b1, jump ? jump_addr : exp_next, 1'b0}) begin
                    n_fail++;
                    $display("FAIL rnd_issue c=%0d: got req=%b addr=%h valid=%b expected 1/%h/0",
                             c, rom_req, rom_addr, instr_valid, jump ? jump_addr : exp_next);
                end
            end
            if (jump) exp_next = jump_addr;
        end
        jump = 1'b0;
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_backpressure();
        test_jump_in_req();
        test_jump_in_hold();
        test_jump_with_ack();
        test_wrap();
        test_reset_mid_req();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the Hack CPU. It holds the program counter and issues one request at a time to a variable-latency instruction ROM over a req/ack handshake. It presents each fetched instruction and its address to the decode/execute stage over a valid/ready handshake. That downstream stage feeds the instruction word into the A-register input mux16 and redirects fetch on taken jumps.

## Interface
- ADDR_W, 15, instruction address width (32K-word ROM)
- DATA_W, 16, instruction word width
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; one clock, no other clock domains
- rom_req  out  1  registered; request to ROM, held until rom_ack
- rom_addr  out  ADDR_W  registered; stable for the whole request
- rom_ack  in  1  ROM returns rom_data this cycle
- rom_data  in  DATA_W  instruction word, valid when rom_ack=1
- instr  out  DATA_W  registered fetched instruction
- instr_pc  out  ADDR_W  registered address of instr
- instr_valid  out  1  instr/instr_pc hold a live instruction
- instr_ready  in  1  downstream accepts instr this cycle
- jump  in  1  single-cycle redirect request
- jump_addr  in  ADDR_W  redirect target, sampled when jump=1

## Operation
- Registers: pc, rom_addr, rom_req, instr, instr_pc, instr_valid, kill flag, state.
- States: IDLE, REQ, HOLD.
- Reset values: state=IDLE, pc=0, rom_addr=0, rom_req=0, instr=0, instr_pc=0, instr_valid=0, kill=0.
- IDLE:
  - rom_req=0.
  - Next: rom_addr<=(jump ? jump_addr : pc), pc<=same value, rom_req<=1, go REQ.
  - rom_ack in IDLE is ignored.
- REQ, rom_ack=1, kill=0, jump=0:
  - instr<=rom_data, instr_pc<=rom_addr, instr_valid<=1.
  - pc<=rom_addr+1, modulo 2^ADDR_W (0x7FFF wraps to 0x0000).
  - rom_req<=0, go HOLD.
- REQ, rom_ack=1, kill=1 or jump=1:
  - Discard rom_data, rom_req<=0, kill<=0, go IDLE.
  - If jump=1, pc<=jump_addr.
  - pc is not incremented for a discarded fetch.
- REQ, rom_ack=0, jump=1:
  - pc<=jump_addr, kill<=1, stay REQ.
  - rom_req and rom_addr are unchanged; the request is never abandoned.
  - Repeated jumps before ack: the last jump_addr wins.
- HOLD:
  - instr_valid=1; instr/instr_pc are stable until handoff.
  - instr_ready=1: instr_valid<=0, go IDLE.
  - jump=1: pc<=jump_addr, instr_valid<=0, go IDLE. The instruction is dropped unless instr_ready=1 in the same cycle, in which case the transfer counts.
  - rom_ack in HOLD is ignored.
- instr keeps its last value after instr_valid falls; only instr_valid is meaningful.
- Reset mid-operation: all registers return to reset values on the next edge. An outstanding ROM request is abandoned (rom_req=0). A late rom_ack is ignored in IDLE.

## Timing
- One outstanding ROM request at most. rom_addr changes only on IDLE→REQ.
- First reset-low edge: IDLE. Next edge: rom_req=1, rom_addr=0.
- Zero-wait ROM (rom_ack in the first REQ cycle): instr_valid rises 2 cycles after IDLE.
- Best throughput: one instruction per 3 cycles (IDLE, REQ, HOLD) with instr_ready tied high.
- Each ROM wait cycle adds one cycle.
- jump to the first rom_req for jump_addr:
  - 1 cycle from IDLE.
  - 2 cycles from HOLD.
  - ack cycle + 2 from REQ.
- rom_req, rom_addr, instr, instr_pc and instr_valid are all register outputs, with no combinational input→output paths.

## Test plan
- Reset, zero-wait ROM returning data=addr^16'h8000, instr_ready=1:
  - Expect instr/instr_pc sequence 8000/0000, 8001/0001, 8002/0002.
  - instr_valid pulses every 3rd cycle.
- ROM with 3 wait cycles and instr_ready held low for 5 cycles in HOLD:
  - rom_addr stays stable through all wait cycles.
  - instr holds for all 5 cycles; exactly one handoff occurs.
  - No second rom_req until the handoff.
- jump to 0x1234 while REQ is waiting on addr 0x0002:
  - The ack data is discarded and instr_valid stays 0.
  - The next request is rom_addr=0x1234; the delivered instr_pc is 0x1234.
- jump in HOLD without ready:
  - The held instr is dropped and never accepted.
  - Next fetch uses jump_addr.
- jump coinciding with ack:
  - Data is discarded; the next fetch uses jump_addr.
- jump to 0x7FFF, then consume:
  - Expect instr_pc 0x7FFF, then 0x0000 (wrap).
- reset asserted during REQ with a late rom_ack after release:
  - rom_req drops the next cycle.
  - The late ack is ignored.
  - The first delivered instr_pc is 0x0000.
